multi_cycle_controller: RTL and testbench
=========================================

# multi_cycle_controller

Control-unit FSM that sequences the multi-cycle CPU datapath (PC, instruction/data memory, instruction register, register file, ALU). It decodes the 6-bit opcode from the instruction register and drives every datapath mux select and write enable, one state per cycle. It waits on a memory-ready handshake during memory accesses and halts on an illegal opcode.

## Interface
Parameters:
- none; opcodes and state codes are fixed constants.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  instruction[31:26] from the instruction register
- memReady  in  1  memory access completes this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load if ALU zero
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- memRead  out  1  memory read request
- memWrite  out  1  memory write request
- irWrite  out  1  instruction register load
- memToReg  out  1  register write data: 0 = ALUOut, 1 = MDR
- regDst  out  1  destination: 0 = rt, 1 = rd
- regWrite  out  1  register file write enable
- aluSrcA  out  1  0 = PC, 1 = register A
- aluSrcB  out  2  00 = B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- aluOp  out  2  00 = add, 01 = sub, 10 = funct field
- pcSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- halted  out  1  illegal opcode seen; core stopped
- state  out  4  current state, for debug/waveforms

## Operation
- Opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000; anything else is illegal.
- States/codes: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BEQ 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 12. Codes 13–15 go to FETCH.
- FETCH: memRead, aluSrcB=01, aluOp=00, pcSource=00; irWrite = pcWrite = memReady. Stays until memReady=1, then DECODE.
- DECODE: aluSrcB=11, aluOp=00 (branch target into ALUOut). Next state by opcode: LW/SW→MEM_ADR, R→R_EX, BEQ→BEQ, J→JUMP, ADDI→ADDI_EX, illegal→HALT.
- MEM_ADR: aluSrcA=1, aluSrcB=10, aluOp=00. LW→MEM_RD, SW→MEM_WR.
- MEM_RD: memRead, iorD=1. Holds until memReady, then MEM_WB.
- MEM_WB: regWrite, memToReg=1, regDst=0. Then FETCH.
- MEM_WR: memWrite, iorD=1. Holds until memReady, then FETCH.
- R_EX: aluSrcA=1, aluSrcB=00, aluOp=10. Then R_WB: regWrite, regDst=1, memToReg=0. Then FETCH.
- BEQ: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond, pcSource=01. Then FETCH.
- JUMP: pcWrite, pcSource=10. Then FETCH.
- ADDI_EX: aluSrcA=1, aluSrcB=10, aluOp=00. Then ADDI_WB: regWrite, regDst=0, memToReg=0. Then FETCH.
- HALT: all enables 0, halted=1. Stays until reset.
- Unlisted outputs in each state are 0. No enable may be asserted outside the states listed above.

## Timing
- Outputs are Moore decodes of the registered state, except irWrite and pcWrite in FETCH, which are qualified by memReady.
- Reset: asynchronous entry to FETCH on rst low. While in reset, outputs equal the FETCH decode: memRead=1, aluSrcB=01, irWrite = pcWrite = memReady. All other outputs are 0, halted=0, and state=0. First transition occurs on the first rising edge after rst rises.
- Cycles per instruction with memReady held at 1: R 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4.
- Each cycle memReady is low in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs stay constant during the wait.
- memReady is ignored in all other states.
- Reset asserted mid-instruction abandons the instruction immediately. No partial write enable may persist.

## Structure
- Shared package cpu_defs: opcode constants, state encodings, aluOp/aluSrcB/pcSource encodings. The ALU-control block uses the same package.
- One sub-module is natural: multi_cycle_next_state, the combinational next-state logic from state, opcode and memReady. Output decode stays in the top.

## Test plan
- Reset, then memReady=1 and opcode R-type: state sequence 0,1,6,7,0. regWrite=1 with regDst=1 only in state 7.
- LW with memReady low for 2 cycles in MEM_RD: sequence 0,1,2,3,3,3,4,0. memRead and iorD held at 1 through the stall.
- SW, BEQ, J, ADDI back to back with memReady=1: per-instruction lengths 4, 3, 3, 4. pcWriteCond=1 only in BEQ; pcSource=10 in JUMP.
- FETCH with memReady=0 for 3 cycles: irWrite=0 and pcWrite=0 throughout. Both pulse for exactly one cycle when memReady rises.
- Opcode 111111 at DECODE: HALT, halted=1, all enables 0 for 20 cycles. After pulsing rst low: state=0, halted=0.
- rst pulsed low mid-MEM_WR, between clock edges: state=0 and memWrite=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared CPU definitions: opcodes, controller state codes and datapath select encodings.
// The ALU-control block imports the same package.
package cpu_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EX    = 4'd6,
        S_R_WB    = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Control bus between the multi-cycle controller (master) and the datapath (slave).
interface multi_cycle_controller_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, halted, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
               pcSource, halted, state
    );
endinterface

// File: rtl/multi_cycle_controller_next_state.sv
// Combinational next-state logic of the multi-cycle controller.
module multi_cycle_next_state
    import cpu_defs::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output state_t     next_state
);

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MEM_ADR;
                    OP_RTYPE:     next_state = S_R_EX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_J:         next_state = S_JUMP;
                    OP_ADDI:      next_state = S_ADDI_EX;
                    default:      next_state = S_HALT;
                endcase
            end
            // The IR holds the opcode, so only LW/SW can reach here; anything else refetches.
            S_MEM_ADR: begin
                if (opcode == OP_LW)
                    next_state = S_MEM_RD;
                else if (opcode == OP_SW)
                    next_state = S_MEM_WR;
                else
                    next_state = S_FETCH;
            end
            S_MEM_RD:  next_state = memReady ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:  next_state = memReady ? S_FETCH : S_MEM_WR;
            S_R_EX:    next_state = S_R_WB;
            S_ADDI_EX: next_state = S_ADDI_WB;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Control-unit FSM for the multi-cycle CPU: state register plus Moore output decode.
// Only irWrite/pcWrite in FETCH look at memReady, so they fire on the cycle the fetch completes.
module multi_cycle_controller
    import cpu_defs::*;
(
    input  logic                      clk,
    input  logic                      rst,
    multi_cycle_controller_if.master  bus
);

    state_t state_q;
    state_t state_d;

    multi_cycle_next_state u_next_state (
        .state      (state_q),
        .opcode     (bus.opcode),
        .memReady   (bus.memReady),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.iorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memToReg    = 1'b0;
        bus.regDst      = 1'b0;
        bus.regWrite    = 1'b0;
        bus.aluSrcA     = 1'b0;
        bus.aluSrcB     = SRCB_B;
        bus.aluOp       = ALU_ADD;
        bus.pcSource    = PC_ALU;
        bus.halted      = 1'b0;
        bus.state       = state_q;
        case (state_q)
            S_FETCH: begin
                bus.memRead  = 1'b1;
                bus.aluSrcB  = SRCB_FOUR;
                bus.irWrite  = bus.memReady;
                bus.pcWrite  = bus.memReady;
            end
            S_DECODE: begin
                bus.aluSrcB  = SRCB_IMM_SH2;
            end
            S_MEM_ADR, S_ADDI_EX: begin
                bus.aluSrcA  = 1'b1;
                bus.aluSrcB  = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.memRead  = 1'b1;
                bus.iorD     = 1'b1;
            end
            S_MEM_WB: begin
                bus.regWrite = 1'b1;
                bus.memToReg = 1'b1;
            end
            S_MEM_WR: begin
                bus.memWrite = 1'b1;
                bus.iorD     = 1'b1;
            end
            S_R_EX: begin
                bus.aluSrcA  = 1'b1;
                bus.aluOp    = ALU_FUNCT;
            end
            S_R_WB: begin
                bus.regWrite = 1'b1;
                bus.regDst   = 1'b1;
            end
            S_BEQ: begin
                bus.aluSrcA     = 1'b1;
                bus.aluOp       = ALU_SUB;
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = PC_ALUOUT;
            end
            S_JUMP: begin
                bus.pcWrite  = 1'b1;
                bus.pcSource = PC_JUMP;
            end
            S_ADDI_WB: begin
                bus.regWrite = 1'b1;
            end
            S_HALT: begin
                bus.halted   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: directed instruction scenarios plus randomized instruction streams
// compared against a per-instruction phase-list model of the controller.
module tb_multi_cycle_controller;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    multi_cycle_controller_if bus ();

    multi_cycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [5:0] R_OP    = 6'b000000;
    localparam logic [5:0] LW_OP   = 6'b100011;
    localparam logic [5:0] SW_OP   = 6'b101011;
    localparam logic [5:0] BEQ_OP  = 6'b000100;
    localparam logic [5:0] J_OP    = 6'b000010;
    localparam logic [5:0] ADDI_OP = 6'b001000;

    // Expected control word {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,
    // memToReg,regDst,regWrite,aluSrcA,aluSrcB,aluOp,pcSource,halted} for a state code.
    function automatic logic [16:0] expCtrl(input int s, input logic mr);
        logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, hlt;
        logic [1:0] srcb, aop, psrc;
        {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, hlt} = '0;
        srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pw = mr; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin srca = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            9:  begin pw = 1; psrc = 2'b10; end
            10: begin srca = 1; srcb = 2'b10; end
            11: rw = 1;
            12: hlt = 1;
            default: ;
        endcase
        return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aop, psrc, hlt};
    endfunction

    function automatic logic [16:0] obsCtrl();
        return {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite,
                bus.irWrite, bus.memToReg, bus.regDst, bus.regWrite, bus.aluSrcA,
                bus.aluSrcB, bus.aluOp, bus.pcSource, bus.halted};
    endfunction

    function automatic int cpi(input logic [5:0] op);
        case (op)
            R_OP:    return 4;
            LW_OP:   return 5;
            SW_OP:   return 4;
            BEQ_OP:  return 3;
            J_OP:    return 3;
            ADDI_OP: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic applyStimulus(input logic mr);
        bus.memReady = mr;
    endtask

    task automatic checkOutput(input string tag, input int expState, input logic mr);
        logic [16:0] e;
        logic [16:0] o;
        e = expCtrl(expState, mr);
        o = obsCtrl();
        total++;
        assert (bus.state === 4'(expState))
        else begin
            bad++;
            $error("FAIL %s state: observed=%0d expected=%0d", tag, bus.state, expState);
        end
        total++;
        assert (o === e)
        else begin
            bad++;
            $error("FAIL %s ctrl (state %0d): observed=%05h expected=%05h", tag, expState, o, e);
        end
    endtask

    // Runs one instruction; memReady is either random or low for the given stall counts.
    // abortState >= 0 pulses reset between edges once that state is reached.
    task automatic runInstr(input string tag, input logic [5:0] op, input int fstall,
                            input int mstall, input bit rnd, input int abortState);
        int   path[$];
        int   idx, cycles, stalls, cur, fl, ml;
        bit   waitSt, legal;
        logic mr;
        path = {0, 1};
        legal = 1;
        case (op)
            LW_OP:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
            SW_OP:   begin path.push_back(2); path.push_back(5); end
            R_OP:    begin path.push_back(6); path.push_back(7); end
            BEQ_OP:  path.push_back(8);
            J_OP:    path.push_back(9);
            ADDI_OP: begin path.push_back(10); path.push_back(11); end
            default: begin
                legal = 0;
                for (int k = 0; k < 20; k++) path.push_back(12);
            end
        endcase
        bus.opcode = op;
        idx = 0; cycles = 0; stalls = 0; fl = fstall; ml = mstall;
        while (idx < path.size()) begin
            cur = path[idx];
            waitSt = (cur == 0 || cur == 3 || cur == 5);
            if (rnd)                            mr = ($urandom_range(0, 9) < 7);
            else if (waitSt && cur == 0 && fl > 0) begin mr = 0; fl--; end
            else if (waitSt && cur != 0 && ml > 0) begin mr = 0; ml--; end
            else                                mr = 1;
            applyStimulus(mr);
            #2;
            checkOutput(tag, cur, mr);
            if (cur == abortState) begin
                rst = 1'b0;
                #1;
                checkOutput({tag, "_abort"}, 0, mr);
                applyStimulus(1'b0);
                #2;
                rst = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (waitSt && !mr) stalls++;
            else               idx++;
            if (cycles > 300) begin
                total++;
                assert (cycles <= 300)
                else begin
                    bad++;
                    $error("FAIL %s timeout: observed=%0d cycles expected<=300", tag, cycles);
                end
                return;
            end
        end
        if (legal) begin
            total++;
            assert (cycles === cpi(op) + stalls)
            else begin
                bad++;
                $error("FAIL %s cycles: observed=%0d expected=%0d", tag, cycles, cpi(op) + stalls);
            end
        end
    endtask

    initial begin
        logic [5:0] ops [6];
        ops = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP};
        rst = 1'b0;
        bus.opcode = 6'd0;
        applyStimulus(1'b1);
        #2;
        checkOutput("reset_rdy", 0, 1'b1);
        applyStimulus(1'b0);
        #1;
        checkOutput("reset_nordy", 0, 1'b0);
        #6;
        rst = 1'b1;
        @(posedge clk);
        #1;

        runInstr("r_type",   R_OP,    0, 0, 0, -1);
        runInstr("lw_stall", LW_OP,   0, 2, 0, -1);
        runInstr("sw",       SW_OP,   0, 0, 0, -1);
        runInstr("beq",      BEQ_OP,  0, 0, 0, -1);
        runInstr("jump",     J_OP,    0, 0, 0, -1);
        runInstr("addi",     ADDI_OP, 0, 0, 0, -1);
        runInstr("fetch_wait", R_OP,  3, 0, 0, -1);
        runInstr("sw_abort", SW_OP,   0, 3, 0, 5);
        runInstr("after_abort", LW_OP, 1, 1, 0, -1);

        for (int n = 0; n < 40; n++)
            runInstr("random", ops[$urandom_range(0, 5)], 0, 0, 1, -1);

        runInstr("halt", 6'b111111, 0, 0, 1, -1);
        rst = 1'b0;
        #1;
        checkOutput("halt_reset", 0, bus.memReady);
        applyStimulus(1'b0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        runInstr("post_halt", ADDI_OP, 0, 0, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
